// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian bytes into words, writes them from BASE_ADDR, then releases core_reset.
// Optional checksum trailer is compiled in with `define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned                  ADDR_WIDTH = 32,
    parameter logic        [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0100_0000),
    parameter int unsigned                  MAX_WORDS  = 1024,
    parameter int unsigned                  CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wr_data,
    output logic [CNT_WIDTH-1:0]  words_loaded,
    output logic                  done,
    output logic                  error,
    output logic                  core_reset
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           shift_q, shift_d;
    logic [CNT_WIDTH-1:0]  n_words_q, n_words_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wr_data_q, mem_wr_data_d;
    logic [CNT_WIDTH-1:0]  words_loaded_q, words_loaded_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  core_reset_q, core_reset_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif

    logic        xfer;
    logic [31:0] assembled;

    assign xfer      = in_valid && in_ready_q;
    // Incoming byte enters at the top, so after four bytes byte 0 sits in [7:0].
    assign assembled = {in_data, shift_q[31:8]};

    // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        shift_d        = shift_q;
        n_words_d      = n_words_q;
        mem_wr_en_d    = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        words_loaded_d = words_loaded_q;
        done_d         = done_q;
        error_d        = error_q;
        core_reset_d   = core_reset_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d          = sum_q;
`endif

        if (xfer) begin
            shift_d    = assembled;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                case (state_q)
                    S_HDR: begin
                        if (assembled == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d      = S_DONE;
                            done_d       = 1'b1;
                            core_reset_d = 1'b0;
`endif
                        end else if (assembled > 32'(MAX_WORDS)) begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d   = S_LOAD;
                            n_words_d = CNT_WIDTH'(assembled);
                        end
                    end
                    S_LOAD: begin
                        mem_wr_en_d    = 1'b1;
                        mem_addr_d     = BASE_ADDR + ADDR_WIDTH'({words_loaded_q, 2'b00});
                        mem_wr_data_d  = assembled;
                        words_loaded_d = words_loaded_q + CNT_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                        sum_d          = sum_q + assembled;
                        if (words_loaded_d == n_words_q) state_d = S_CSUM;
`else
                        // done follows one cycle after this write pulse, via the S_DONE hold below.
                        if (words_loaded_d == n_words_q) state_d = S_DONE;
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (assembled == sum_q) begin
                            state_d      = S_DONE;
                            done_d       = 1'b1;
                            core_reset_d = 1'b0;
                        end else begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        if (state_q == S_DONE) begin
            done_d       = 1'b1;
            core_reset_d = 1'b0;
        end

        in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CSUM);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_HDR;
            byte_idx_q     <= 2'd0;
            shift_q        <= 32'd0;
            n_words_q      <= '0;
            in_ready_q     <= 1'b0;
            mem_wr_en_q    <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_wr_data_q  <= 32'd0;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            core_reset_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            shift_q        <= shift_d;
            n_words_q      <= n_words_d;
            in_ready_q     <= in_ready_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            words_loaded_q <= words_loaded_d;
            done_q         <= done_d;
            error_q        <= error_d;
            core_reset_q   <= core_reset_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign words_loaded = words_loaded_q;
    assign done         = done_q;
    assign error        = error_q;
    assign core_reset   = core_reset_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Accepts a little-endian byte stream over a valid/ready handshake and packs it into 32-bit words. Writes the words into instruction memory starting at BASE_ADDR.
- Holds the core in reset via core_reset until the program image is fully loaded.
- Sits between the bench/host byte source and the imem write port, alongside the pd core in design_wrapper.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr.
- BASE_ADDR, 32'h0100_0000, byte address of the first written word.
- MAX_WORDS, 1024, largest accepted image size in words.
- CNT_WIDTH, 16, width of the header count and of words_loaded.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte source has data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- mem_wr_en  out  1  one-cycle imem write strobe.
- mem_addr  out  ADDR_WIDTH  imem byte address, word aligned.
- mem_wr_data  out  32  imem write data.
- words_loaded  out  CNT_WIDTH  data words written so far.
- done  out  1  image loaded; sticky until reset.
- error  out  1  load rejected; sticky until reset.
- core_reset  out  1  reset to pd core; high until done.

Behaviour:
- One clock domain; reset is synchronous and active-high. Port names are clock and reset.
- All outputs are registered.
- Reset values: in_ready=0, mem_wr_en=0, mem_addr=BASE_ADDR, mem_wr_data=0, words_loaded=0, done=0, error=0, core_reset=1. State goes to HDR, byte index to 0.
- in_ready rises the first cycle after reset deasserts. It is high in HDR, LOAD and CSUM, and low in DONE and ERR.
- A byte transfers on a rising edge where in_valid && in_ready. No transfer means no state change.
- Packing: byte k (k=0..3) of each group goes to bits [8k+7:8k], little-endian.
- State HDR: collect 4 bytes as word count N.
  - N==0: DONE.
  - N>MAX_WORDS: ERR.
  - Otherwise: LOAD.
- State LOAD: on the 4th byte of word i (i=0..N-1), the next cycle drives:
  - mem_wr_en=1 for exactly one cycle;
  - mem_addr = BASE_ADDR + 4*i, computed modulo 2^ADDR_WIDTH;
  - mem_wr_data = the packed word;
  - words_loaded = i+1 in the same cycle.
  - After word N-1: go to DONE, or to CSUM if the optional feature is compiled in.
- Streaming: in_ready stays high during the write cycle. Back-to-back bytes sustain 1 byte/cycle with no stall.
- State DONE: done=1 and core_reset=0 in the cycle after the final mem_wr_en pulse. For N==0, this is the cycle after the 4th header byte. Sticky.
- State ERR: error=1, core_reset=1, no further writes. Sticky until reset.
- Reset asserted mid-load: immediately returns to reset values on the next edge. Partial byte groups are discarded; memory already written is not rolled back. A new load restarts from the header.
- in_valid held high in DONE/ERR: ignored, no transfer.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, state CSUM collects 4 more bytes, little-endian, as checksum C.
  - The expected value is the sum of all N data words mod 2^32. For N==0 the expected value is 0, and CSUM is still entered.
  - C matches: go to DONE, with done/core_reset timing one cycle after the 4th checksum byte.
  - Mismatch: go to ERR.
- Undefined: no CSUM state; LOAD goes directly to DONE as described above.

Test Plan:
- Reset, then header 02 00 00 00, then bytes 13 00 00 00 and 93 00 10 00 streamed back-to-back.
  - Write pulses: addr 0x01000000 data 0x00000013, and addr 0x01000004 data 0x00100093.
  - words_loaded reaches 2; done=1 and core_reset=0 one cycle after the second pulse.
- Header 00 00 00 00 -> no mem_wr_en; done=1 the cycle after the 4th byte; in_ready=0.
- Header 01 04 00 00 (N=1025 > 1024) -> error=1, core_reset=1, in_ready=0, no writes.
- Same 2-word image with in_valid toggling every other cycle -> identical writes and values; bytes are transferred only on valid&&ready edges.
- Assert reset after 6 bytes of a 3-word load, then reload a 1-word image AABBCCDD (bytes DD CC BB AA).
  - One write: addr 0x01000000, data 0xAABBCCDD; words_loaded=1.
- With LOADER_CHECKSUM_EN defined, 2-word image above:
  - Checksum A6 00 10 00 (0x001000A6) -> done=1.
  - Checksum A7 00 10 00 -> error=1, core_reset stays 1.
